// File: rtl/timer_cmp_ctrl_if.sv
// timer_cmp_ctrl_if: register bus and interrupt line of the timer compare controller
interface timer_cmp_ctrl_if;
  logic        wen;
  logic        ren;
  logic [3:0]  addr_ofs;
  logic [31:0] wdata;
  logic [31:0] data_o;
  logic        irq_o;
  modport master (output wen, ren, addr_ofs, wdata, input data_o, irq_o);
  modport slave  (input wen, ren, addr_ofs, wdata, output data_o, irq_o);
endinterface

// File: rtl/timer_cmp_ctrl.sv
// timer_cmp_ctrl: 64-bit timer compare with one-shot/periodic modes and a level interrupt
module timer_cmp_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       mtime_i,
  timer_cmp_ctrl_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, FIRED = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d, data_q, data_d, rd;
  logic        en_q, en_d, per_q, per_d, pend_q, pend_d;
  logic        wr_lo, wr_hi, wr_ctrl, wr_per, hit, auto, reload;
  always_comb begin
    wr_lo    = bus.wen && bus.addr_ofs == 4'h0;
    wr_hi    = bus.wen && bus.addr_ofs == 4'h4;
    wr_ctrl  = bus.wen && bus.addr_ofs == 4'h8;
    wr_per   = bus.wen && bus.addr_ofs == 4'hC;
    // a same-cycle write disabling the block suppresses the match
    hit      = state_q == ARMED && en_q && mtime_i >= cmp_q && !(wr_ctrl && !bus.wdata[0]);
    auto     = per_q && |period_q;
    reload   = hit && auto && !(wr_lo || wr_hi);
    cmp_d    = reload ? cmp_q + {32'd0, period_q}
                      : {wr_hi ? bus.wdata : cmp_q[63:32], wr_lo ? bus.wdata : cmp_q[31:0]};
    period_d = wr_per ? bus.wdata : period_q;
    en_d     = wr_ctrl ? bus.wdata[0] : en_q;
    per_d    = wr_ctrl ? bus.wdata[1] : per_q;
    pend_d   = hit || (pend_q && !(wr_ctrl && bus.wdata[8]));
    state_d  = !en_q             ? IDLE :
               state_q == IDLE   ? ARMED :
               state_q == ARMED  ? ((hit && !auto) ? FIRED : ARMED) :
               state_q == FIRED  ? ((wr_lo || wr_hi) ? ARMED : FIRED) : IDLE;
    rd       = bus.addr_ofs == 4'h0 ? cmp_q[31:0] :
               bus.addr_ofs == 4'h4 ? cmp_q[63:32] :
               bus.addr_ofs == 4'h8 ? {23'd0, pend_q, 6'd0, per_q, en_q} :
               bus.addr_ofs == 4'hC ? period_q : 32'd0;
    data_d   = bus.ren ? rd : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      period_q <= 32'd0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      pend_q   <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      en_q     <= en_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
    end
  end
  assign bus.data_o = data_q;
  assign bus.irq_o  = pend_q;
endmodule
